// File: rtl/asng_pkg.sv
// Shared types, tap masks and the LFSR step function
// for the alternating stop-and-go keystream controller.
package asng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } state_e;

  // Tap masks: bit i set means r[i] feeds the XOR.
  // r1: 31,21,1,0  r2: 31,29,25,24  r3: 31,30,29,9
  localparam logic [31:0] TAPS_R1 = 32'h8020_0003;
  localparam logic [31:0] TAPS_R2 = 32'hA300_0000;
  localparam logic [31:0] TAPS_R3 = 32'hE000_0200;

  localparam logic [31:0] ZERO_SUB = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] r,
    input logic [31:0] taps
  );
    return {r[30:0], ^(r & taps)};
  endfunction

endpackage

// File: rtl/asng_lfsr_en.sv
// 32-bit Fibonacci LFSR with clear > load > enable priority.
// Ports: clk, rst_n, clr_i, load_i, load_val_i, en_i, msb_o.
module asng_lfsr_en
  import asng_pkg::*;
#(
  parameter logic [31:0] TAPS = TAPS_R1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        en_i,
  output logic        msb_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr_i)       state_d = '0;
    else if (load_i) state_d = load_val_i;
    else if (en_i)   state_d = lfsr_step(state_q, TAPS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  assign msb_o = state_q[31];

endmodule

// File: rtl/asng_keystream_ctrl.sv
// Seeds, warms up and steps a stop-and-go keystream generator,
// packing bits MSB-first into OUT_W-bit words on a valid/ready port.
// Ports: clk, rst (async low), start, stop, seed1..3, ks_data,
// ks_valid, ks_ready, busy, seed_err.
// Option: ASNG_ZERO_GUARD_EN substitutes zero seeds with 1.
module asng_keystream_ctrl
  import asng_pkg::*;
#(
  parameter int WARMUP = 64,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      seed1,
  input  logic [31:0]      seed2,
  input  logic [31:0]      seed3,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             seed_err
);

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int CW  = $clog2(OUT_W + 1);
  localparam logic [CW-1:0]  FULL  = CW'(OUT_W);
  localparam logic [CW-1:0]  LAST  = CW'(OUT_W - 1);
  localparam logic [WCW-1:0] WINIT = WCW'(WARMUP - 1);

  state_e state_q, state_d;

  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] pk_q, pk_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             load, step, in_run;
  logic             full, out_free, ks_bit;
  logic             r1_msb, r2_msb, r3_msb;
  logic [31:0]      ld1, ld2, ld3;
  logic [OUT_W-1:0] word;

  assign load     = (state_q == ST_IDLE) & start & !stop;
  assign in_run   = (state_q == ST_RUN);
  assign full     = (cnt_q == FULL);
  assign out_free = !valid_q | ks_ready;
  // Freeze only when a finished word waits behind a held output.
  assign step     = !stop & ((state_q == ST_WARMUP) |
                    (in_run & !(full & !out_free)));
  assign ks_bit   = r2_msb ^ r3_msb;
  assign word     = {pk_q[OUT_W-2:0], ks_bit};

`ifdef ASNG_ZERO_GUARD_EN
  assign ld1 = (seed1 == '0) ? ZERO_SUB : seed1;
  assign ld2 = (seed2 == '0) ? ZERO_SUB : seed2;
  assign ld3 = (seed3 == '0) ? ZERO_SUB : seed3;
`else
  assign ld1 = seed1;
  assign ld2 = seed2;
  assign ld3 = seed3;
`endif

  asng_lfsr_en #(.TAPS(TAPS_R1)) u_r1 (
    .clk(clk), .rst_n(rst), .clr_i(stop), .load_i(load),
    .load_val_i(ld1), .en_i(step), .msb_o(r1_msb)
  );

  asng_lfsr_en #(.TAPS(TAPS_R2)) u_r2 (
    .clk(clk), .rst_n(rst), .clr_i(stop), .load_i(load),
    .load_val_i(ld2), .en_i(step & r1_msb), .msb_o(r2_msb)
  );

  asng_lfsr_en #(.TAPS(TAPS_R3)) u_r3 (
    .clk(clk), .rst_n(rst), .clr_i(stop), .load_i(load),
    .load_val_i(ld3), .en_i(step & !r1_msb), .msb_o(r3_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start) state_d = ST_WARMUP;
        ST_WARMUP: if (wcnt_q == '0) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    wcnt_d = wcnt_q;
    err_d  = err_q;
    if (stop) begin
      wcnt_d = '0;
    end else if (load) begin
      wcnt_d = WINIT;
      err_d  = (seed1 == '0) | (seed2 == '0) | (seed3 == '0);
    end else if (state_q == ST_WARMUP && wcnt_q != '0) begin
      wcnt_d = wcnt_q - WCW'(1);
    end
  end

  always_comb begin
    pk_d    = pk_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q & !ks_ready;
    if (stop) begin
      pk_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (in_run) begin
      if (full) begin
        // Parked word leaves; this cycle's bit starts a new word.
        if (out_free) begin
          data_d  = pk_q;
          valid_d = 1'b1;
          pk_d    = {{(OUT_W-1){1'b0}}, ks_bit};
          cnt_d   = CW'(1);
        end
      end else if (cnt_q == LAST) begin
        if (out_free) begin
          data_d  = word;
          valid_d = 1'b1;
          pk_d    = '0;
          cnt_d   = '0;
        end else begin
          pk_d  = word;
          cnt_d = FULL;
        end
      end else begin
        pk_d  = word;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q  <= '0;
      cnt_q   <= '0;
      pk_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      pk_q    <= pk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ks_data  = data_q;
  assign ks_valid = valid_q;
  assign seed_err = err_q;

endmodule
